// File: rtl/ca_reg_seq_ctrl.sv
// Digit sequencer for the online multiplier CA register.
// Takes (x,y) digit pairs over valid/ready, appends ONLINE_DELAY zero pairs,
// and drives x_input/y_input/cnt/computation_cycles/wr_en/word_done.
// Ports: clk, rst (sync, active-high), start/op_digits (launch),
// in_valid/in_ready/x_digit/y_digit (digit stream), x_input/y_input/cnt/
// computation_cycles/wr_en/word_done (register write), busy/done/digit_err.
module ca_reg_seq_ctrl #(
  parameter int ONLINE_DELAY         = 2,
  parameter int DIGITS_PER_WORD_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] op_digits,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] x_digit,
  input  logic [1:0] y_digit,
  output logic [1:0] x_input,
  output logic [1:0] y_input,
  output logic [6:0] cnt,
  output logic [4:0] computation_cycles,
  output logic       wr_en,
  output logic       word_done,
  output logic       busy,
  output logic       done,
  output logic       digit_err
);

  localparam int         SW   = DIGITS_PER_WORD_LOG2;
  localparam logic [7:0] MAXN = 8'(128 - ONLINE_DELAY);
  localparam logic [3:0] DLY  = 4'(ONLINE_DELAY);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  state_t     state;
  logic [7:0] n_lat;
  logic [7:0] ld;
  logic [7:0] wcnt;
  logic [3:0] fcnt;

  logic [7:0] n_req;
  logic [7:0] n_clmp;
  logic [1:0] xn;
  logic [1:0] yn;
  logic       bad_dig;
  logic       last_ld;
  logic       word_end;
  logic       last_fl;

  always_comb begin
    n_req    = {1'b0, op_digits};
    n_clmp   = (n_req > MAXN) ? MAXN : n_req;
    xn       = (x_digit == 2'b11) ? 2'b00 : x_digit;
    yn       = (y_digit == 2'b11) ? 2'b00 : y_digit;
    bad_dig  = (&x_digit) | (&y_digit);
    last_ld  = (ld + 8'd1) == n_lat;
    word_end = &wcnt[SW-1:0];
    last_fl  = (fcnt + 4'd1) == DLY;
  end

  assign in_ready = (state == LOAD);

  // FLUSH spends one extra non-writing cycle once all zeros are generated,
  // so done lands exactly one cycle after the last presented write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      n_lat              <= '0;
      ld                 <= '0;
      wcnt               <= '0;
      fcnt               <= '0;
      x_input            <= '0;
      y_input            <= '0;
      cnt                <= '0;
      computation_cycles <= '0;
      wr_en              <= 1'b0;
      word_done          <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      digit_err          <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      word_done <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            n_lat              <= n_clmp;
            ld                 <= '0;
            wcnt               <= '0;
            fcnt               <= '0;
            cnt                <= '0;
            computation_cycles <= '0;
            digit_err          <= 1'b0;
            busy               <= 1'b1;
            if (n_clmp != 8'd0) begin
              state <= LOAD;
            end else if (DLY != 4'd0) begin
              state <= FLUSH;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            wr_en              <= 1'b1;
            x_input            <= xn;
            y_input            <= yn;
            cnt                <= wcnt[6:0];
            computation_cycles <= wcnt[6:SW];
            word_done          <= word_end | (last_ld & (DLY == 4'd0));
            wcnt               <= wcnt + 8'd1;
            ld                 <= ld + 8'd1;
            if (bad_dig) digit_err <= 1'b1;
            if (last_ld) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (fcnt != DLY) begin
            wr_en              <= 1'b1;
            x_input            <= 2'b00;
            y_input            <= 2'b00;
            cnt                <= wcnt[6:0];
            computation_cycles <= wcnt[6:SW];
            word_done          <= word_end | last_fl;
            wcnt               <= wcnt + 8'd1;
            fcnt               <= fcnt + 4'd1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ca_reg_seq_ctrl.sv
// Scoreboard bench for ca_reg_seq_ctrl.
// Reference model predicts every register write from the digit stream.
module tb_ca_reg_seq_ctrl;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] op_digits;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] x_digit;
  logic [1:0] y_digit;
  logic [1:0] x_input;
  logic [1:0] y_input;
  logic [6:0] cnt;
  logic [4:0] computation_cycles;
  logic       wr_en;
  logic       word_done;
  logic       busy;
  logic       done;
  logic       digit_err;

  ca_reg_seq_ctrl #(
    .ONLINE_DELAY(D),
    .DIGITS_PER_WORD_LOG2(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op_digits(op_digits),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x_digit(x_digit),
    .y_digit(y_digit),
    .x_input(x_input),
    .y_input(y_input),
    .cnt(cnt),
    .computation_cycles(computation_cycles),
    .wr_en(wr_en),
    .word_done(word_done),
    .busy(busy),
    .done(done),
    .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic [6:0] c;
    logic [4:0] cc;
    logic       wd;
  } wr_t;

  wr_t q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  last_wr_cyc = 0;
  int  exp_done = 0;
  bit  exp_err = 0;
  int  op_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Expected write number i of an op with op_total writes in all.
  function automatic void push_wr(int i, int x, int y);
    wr_t e;
    e.x  = 2'(x == 3 ? 0 : x);
    e.y  = 2'(y == 3 ? 0 : y);
    e.c  = 7'(i);
    e.cc = 5'(i / 4);
    e.wd = (i % 4 == 3) || (i == op_total - 1);
    q.push_back(e);
  endfunction

  // Monitor: pops the scoreboard on every write, checks done timing.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got cnt=%0d want none", cnt);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("x_input", int'(x_input), int'(e.x));
          chk("y_input", int'(y_input), int'(e.y));
          chk("cnt", int'(cnt), int'(e.c));
          chk("computation_cycles", int'(computation_cycles), int'(e.cc));
          chk("word_done", int'(word_done), int'(e.wd));
        end
        chk("done_with_write", int'(done), 0);
        last_wr_cyc = cyc;
      end
      if (done) begin
        if (exp_done == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got 1 want 0 (cycle %0d)", cyc);
        end else begin
          chk("done_latency", cyc - last_wr_cyc, 1);
          chk("writes_left_at_done", q.size(), 0);
          chk("digit_err_at_done", int'(digit_err), int'(exp_err));
          exp_done = 0;
        end
      end
    end
  end

  task automatic run_op(input int op, input int pct, input int bad_idx,
                        input bit allow3, input bit noise,
                        input bit use_pat, input logic [15:0] pat);
    int  n;
    int  sent;
    int  t;
    int  xv;
    int  yv;
    bit  acc;
    n = (op > 128 - D) ? 128 - D : op;
    op_total = n + D;
    @(negedge clk);
    start     = 1'b1;
    op_digits = 7'(op);
    exp_done  = 1;
    exp_err   = 0;
    if (n == 0)
      for (int j = 0; j < D; j++) push_wr(j, 0, 0);
    @(negedge clk);
    start = 1'b0;
    chk("err_clear_on_start", int'(digit_err), 0);
    chk("busy_after_start", int'(busy), 1);
    sent = 0;
    t = 0;
    while (sent < n && t < 1000) begin
      in_valid = use_pat ? pat[t % 16] : ($urandom_range(0, 99) < pct);
      xv = $urandom_range(0, allow3 ? 3 : 2);
      yv = $urandom_range(0, allow3 ? 3 : 2);
      if (sent == bad_idx) xv = 3;
      x_digit = 2'(xv);
      y_digit = 2'(yv);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = in_valid && in_ready;
      if (acc) begin
        push_wr(sent, xv, yv);
        if (xv == 3 || yv == 3) exp_err = 1;
        sent++;
        if (sent == n)
          for (int j = 0; j < D; j++) push_wr(n + j, 0, 0);
      end
      t++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (sent < n) begin
      total++;
      bad++;
      $display("FAIL load_timeout: got %0d transfers want %0d", sent, n);
    end
    t = 0;
    while (!done && t < 400) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done");
      exp_done = 0;
      q.delete();
    end else begin
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      chk("done_one_cycle", int'(done), 0);
    end
  endtask

  task automatic reset_mid_load();
    op_total = 10 + D;
    exp_done = 0;
    @(negedge clk);
    start     = 1'b1;
    op_digits = 7'd10;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x_digit  = 2'(i);
      y_digit  = 2'(2 - i);
      push_wr(i, i, 2 - i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_writes_seen", q.size(), 0);
    q.delete();
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    op_digits = '0;
    in_valid  = 1'b0;
    x_digit   = '0;
    y_digit   = '0;
    repeat (3) @(negedge clk);
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_cnt", int'(cnt), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_digit_err", int'(digit_err), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    rst = 1'b0;

    run_op(5, 100, -1, 0, 0, 0, 16'h0);
    run_op(4, 100, -1, 0, 0, 1, 16'h0059);
    run_op(4, 100, 1, 0, 0, 0, 16'h0);
    run_op(3, 100, -1, 0, 0, 0, 16'h0);
    reset_mid_load();
    run_op(5, 100, -1, 0, 0, 0, 16'h0);
    run_op(0, 100, -1, 0, 0, 0, 16'h0);
    run_op(127, 100, -1, 0, 0, 0, 16'h0);
    run_op(126, 80, -1, 1, 0, 0, 16'h0);
    run_op(6, 70, -1, 0, 1, 0, 16'h0);
    for (int k = 0; k < 8; k++)
      run_op($urandom_range(0, 40), 60, -1, 1, 1, 0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
